// File: rtl/cash_payment_accumulator.sv
// rtl/cash_payment_accumulator.sv - note acceptor front end: bill session, running total, change and refund
// Optional idle auto-refund is built only when CASH_TIMEOUT_EN is defined.
module cash_payment_accumulator #(
  parameter int AMT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bill_load,
  input  logic [AMT_W-1:0] bill_amount,
  input  logic             note_valid,
  input  logic [2:0]       note_code,
  input  logic             cancel,
  output logic             note_accept,
  output logic             note_reject,
  output logic [AMT_W-1:0] inserted_total,
  output logic             busy,
  output logic             payment_received,
  output logic [AMT_W-1:0] change_due,
  output logic             change_valid,
  output logic [AMT_W-1:0] refund_amount,
  output logic             refund_valid
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_PAID    = 2'd2;
  localparam logic [1:0] S_REFUND  = 2'd3;

  logic [1:0]       r_state;
  logic [AMT_W-1:0] r_bill;
  logic [AMT_W-1:0] r_total;
  logic             r_accept;
  logic             r_reject;

  logic [AMT_W-1:0] w_denom;
  logic             w_code_ok;
  logic [AMT_W:0]   w_sum;
  logic             w_fits;
  logic             w_timeout;

  always_comb begin
    w_denom   = '0;
    w_code_ok = 1'b1;
    case (note_code)
      3'd0:    w_denom = AMT_W'(10);
      3'd1:    w_denom = AMT_W'(20);
      3'd2:    w_denom = AMT_W'(50);
      3'd3:    w_denom = AMT_W'(100);
      3'd4:    w_denom = AMT_W'(200);
      3'd5:    w_denom = AMT_W'(500);
      default: w_code_ok = 1'b0;
    endcase
  end

  // One extra bit catches a total that would wrap past AMT_W.
  assign w_sum  = {1'b0, r_total} + {1'b0, w_denom};
  assign w_fits = w_code_ok && !w_sum[AMT_W];

`ifdef CASH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_idle_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_idle_cnt <= '0;
    else if (r_state != S_COLLECT || note_valid)
      r_idle_cnt <= '0;
    else
      r_idle_cnt <= r_idle_cnt + 1'b1;
  end

  assign w_timeout = (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_bill   <= '0;
      r_total  <= '0;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_reject <= note_valid;
          if (bill_load && bill_amount != '0) begin
            r_bill  <= bill_amount;
            r_total <= '0;
            r_state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          // Cancel wins over a note presented in the same cycle.
          if (cancel) begin
            r_reject <= note_valid;
            r_state  <= S_REFUND;
          end else if (note_valid) begin
            if (w_fits) begin
              r_accept <= 1'b1;
              r_total  <= w_sum[AMT_W-1:0];
              if (w_sum[AMT_W-1:0] >= r_bill)
                r_state <= S_PAID;
            end else begin
              r_reject <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= S_REFUND;
          end
        end
        S_PAID: begin
          r_reject <= note_valid;
          r_state  <= S_IDLE;
        end
        default: begin
          r_reject <= note_valid;
          r_total  <= '0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign note_accept      = r_accept;
  assign note_reject      = r_reject;
  assign inserted_total   = r_total;
  assign busy             = (r_state != S_IDLE);
  assign payment_received = (r_state == S_PAID);
  assign change_valid     = (r_state == S_PAID);
  assign change_due       = (r_state == S_PAID) ? (r_total - r_bill) : '0;
  assign refund_valid     = (r_state == S_REFUND);
  assign refund_amount    = (r_state == S_REFUND) ? r_total : '0;

endmodule

// File: tb/tb_cash_payment_accumulator.sv
// tb/tb_cash_payment_accumulator.sv - directed and randomized check of cash_payment_accumulator
module tb_cash_payment_accumulator;
  localparam int AMT_W = 10;
  localparam int TMO   = 20;
  localparam int MAXV  = (1 << AMT_W) - 1;

  localparam int M_IDLE    = 0;
  localparam int M_COLLECT = 1;
  localparam int M_PAID    = 2;
  localparam int M_REFUND  = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             bill_load = 1'b0;
  logic [AMT_W-1:0] bill_amount = '0;
  logic             note_valid = 1'b0;
  logic [2:0]       note_code = '0;
  logic             cancel = 1'b0;
  logic             note_accept, note_reject, busy, payment_received, change_valid, refund_valid;
  logic [AMT_W-1:0] inserted_total, change_due, refund_amount;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_mode, m_bill, m_total, m_idle;
  int exp_acc, exp_rej, exp_busy, exp_pay, exp_change, exp_rv, exp_ramt;

  cash_payment_accumulator #(.AMT_W(AMT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .bill_load(bill_load), .bill_amount(bill_amount),
    .note_valid(note_valid), .note_code(note_code), .cancel(cancel),
    .note_accept(note_accept), .note_reject(note_reject), .inserted_total(inserted_total),
    .busy(busy), .payment_received(payment_received), .change_due(change_due),
    .change_valid(change_valid), .refund_amount(refund_amount), .refund_valid(refund_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int denom(input int code);
    case (code)
      0: return 10;
      1: return 20;
      2: return 50;
      3: return 100;
      4: return 200;
      5: return 500;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_bill = 0; m_total = 0; m_idle = 0;
    exp_acc = 0; exp_rej = 0; exp_busy = 0; exp_pay = 0; exp_change = 0; exp_rv = 0; exp_ramt = 0;
  endtask

  task automatic model_step(input int bl, input int amt, input int nv, input int code, input int cn);
    int d;
    exp_acc = 0;
    exp_rej = 0;
    case (m_mode)
      M_IDLE: begin
        exp_rej = nv;
        if (bl != 0 && amt != 0) begin
          m_bill = amt; m_total = 0; m_idle = 0; m_mode = M_COLLECT;
        end
      end
      M_COLLECT: begin
        if (cn != 0) begin
          exp_rej = nv;
          m_mode  = M_REFUND;
        end else if (nv != 0) begin
          m_idle = 0;
          d = denom(code);
          if (d < 0 || m_total + d > MAXV) exp_rej = 1;
          else begin
            exp_acc = 1;
            m_total += d;
            if (m_total >= m_bill) m_mode = M_PAID;
          end
        end else begin
          m_idle++;
`ifdef CASH_TIMEOUT_EN
          if (m_idle >= TMO) m_mode = M_REFUND;
`endif
        end
      end
      M_PAID: begin
        exp_rej = nv;
        m_mode  = M_IDLE;
      end
      default: begin
        exp_rej = nv;
        m_total = 0;
        m_mode  = M_IDLE;
      end
    endcase
    exp_busy   = (m_mode != M_IDLE);
    exp_pay    = (m_mode == M_PAID);
    exp_change = (m_mode == M_PAID) ? m_total - m_bill : 0;
    exp_rv     = (m_mode == M_REFUND);
    exp_ramt   = (m_mode == M_REFUND) ? m_total : 0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return at the following negedge.
  task automatic step(input int bl, input int amt, input int nv, input int code, input int cn);
    bill_load   = bl[0];
    bill_amount = amt[AMT_W-1:0];
    note_valid  = nv[0];
    note_code   = code[2:0];
    cancel      = cn[0];
    @(posedge clk);
    model_step(bl, amt, nv, code, cn);
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("note_accept", note_accept, exp_acc);
      chk("note_reject", note_reject, exp_rej);
      chk("inserted_total", inserted_total, m_total);
      chk("busy", busy, exp_busy);
      chk("payment_received", payment_received, exp_pay);
      chk("change_valid", change_valid, exp_pay);
      chk("change_due", change_due, exp_change);
      chk("refund_valid", refund_valid, exp_rv);
      chk("refund_amount", refund_amount, exp_ramt);
    end
  end

  initial begin
    model_reset();
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_total", inserted_total, 0);
    chk("rst_accept", note_accept, 0);
    chk("rst_reject", note_reject, 0);
    chk("rst_pay", payment_received, 0);
    chk("rst_refund", refund_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Exact payment: 250 from 100+100+50
    step(1, 250, 0, 0, 0);
    step(0, 0, 1, 3, 0);  chk("t1_acc1", note_accept, 1); chk("t1_tot1", inserted_total, 100);
    step(0, 0, 1, 3, 0);  chk("t1_acc2", note_accept, 1); chk("t1_tot2", inserted_total, 200);
    step(0, 0, 1, 2, 0);  chk("t1_acc3", note_accept, 1); chk("t1_pay", payment_received, 1);
    chk("t1_change", change_due, 0); chk("t1_model_total", m_total, 250);
    idle_step();          chk("t1_busy", busy, 0); chk("t1_hold", inserted_total, 250);

    // Overpayment gives change
    step(1, 120, 0, 0, 0);
    chk("t2_cleared", inserted_total, 0);
    step(0, 0, 1, 3, 0);
    step(0, 0, 1, 2, 0);  chk("t2_pay", payment_received, 1); chk("t2_change", change_due, 30);
    chk("t2_total", inserted_total, 150); chk("t2_model_change", exp_change, 30);
    idle_step();

    // Invalid code, then cancel with refund
    step(1, 300, 0, 0, 0);
    step(0, 0, 1, 6, 0);  chk("t3_rej", note_reject, 1); chk("t3_tot0", inserted_total, 0);
    step(0, 0, 1, 4, 0);  chk("t3_acc", note_accept, 1); chk("t3_tot", inserted_total, 200);
    step(0, 0, 0, 0, 1);  chk("t3_rv", refund_valid, 1); chk("t3_ramt", refund_amount, 200);
    chk("t3_model_ramt", exp_ramt, 200);
    idle_step();          chk("t3_busy", busy, 0); chk("t3_clr", inserted_total, 0);

    // Width boundary: exactly reaching 1000, then an overflowing note
    step(1, 1000, 0, 0, 0);
    step(0, 0, 1, 5, 0);
    step(0, 0, 1, 5, 0);  chk("t4_pay", payment_received, 1); chk("t4_tot", inserted_total, 1000);
    idle_step();
    step(1, 1020, 0, 0, 0);
    step(0, 0, 1, 5, 0);
    step(0, 0, 1, 5, 0);  chk("t4_nopay", payment_received, 0);
    step(0, 0, 1, 2, 0);  chk("t4_ovf_rej", note_reject, 1); chk("t4_ovf_tot", inserted_total, 1000);
    step(0, 0, 0, 0, 1);  chk("t4_ramt", refund_amount, 1000);
    idle_step();

    // Cancel beats a simultaneous note; then asynchronous reset mid-session
    step(1, 500, 0, 0, 0);
    step(0, 0, 1, 3, 0);
    step(0, 0, 1, 3, 1);  chk("t5_rej", note_reject, 1); chk("t5_acc", note_accept, 0);
    chk("t5_rv", refund_valid, 1); chk("t5_ramt", refund_amount, 100);
    idle_step();
    step(1, 500, 0, 0, 0);
    step(0, 0, 1, 4, 0);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0); chk("t5_rst_tot", inserted_total, 0);
    chk("t5_rst_rv", refund_valid, 0); chk("t5_rst_acc", note_accept, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle_step();          chk("t5_post_busy", busy, 0);

    // Idle timeout behaviour
    step(1, 100, 0, 0, 0);
    step(0, 0, 1, 2, 0);
`ifdef CASH_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) idle_step();
    chk("t6_pre", refund_valid, 0);
    idle_step();          chk("t6_rv", refund_valid, 1); chk("t6_ramt", refund_amount, 50);
    idle_step();
`else
    for (int i = 0; i < TMO + 5; i++) idle_step();
    chk("t6_busy", busy, 1); chk("t6_norv", refund_valid, 0);
    step(0, 0, 0, 0, 1);
    idle_step();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int bl, amt, nv, code, cn, sel;
      bl  = ($urandom % 6 == 0) ? 1 : 0;
      sel = $urandom % 4;
      amt = (sel == 0) ? 0 : (sel == 1) ? int'($urandom % 64) : int'($urandom % 1024);
      nv   = int'($urandom % 2);
      code = int'($urandom % 8);
      cn   = ($urandom % 16 == 0) ? 1 : 0;
      step(bl, amt, nv, code, cn);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
